// File: rtl/legv8_pkg.sv
// Shared types and constants for the LEGv8 fetch path.
package legv8_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } fetch_state_t;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 21;
  localparam int unsigned PC_STEP    = 4;
  localparam logic [31:0] INSTR_NOP  = 32'hD503201F;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding register used to park a fetched word while decode is stalled.
module fetch_skid_buf
  import legv8_pkg::*;
#(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               unload,
  input  logic               clear,
  input  logic [ADDR_W-1:0]  inPc,
  input  logic [INSTR_W-1:0] inInstr,
  output logic               full,
  output logic [ADDR_W-1:0]  outPc,
  output logic [INSTR_W-1:0] outInstr
);

  logic               fullQ;
  logic [ADDR_W-1:0]  pcQ;
  logic [INSTR_W-1:0] instrQ;

  // Clear wins over load so a redirect in the same cycle never leaves a stale entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fullQ  <= 1'b0;
      pcQ    <= '0;
      instrQ <= INSTR_W'(INSTR_NOP);
    end else if (clear) begin
      fullQ <= 1'b0;
    end else if (load) begin
      fullQ  <= 1'b1;
      pcQ    <= inPc;
      instrQ <= inInstr;
    end else if (unload) begin
      fullQ <= 1'b0;
    end
  end

  assign full     = fullQ;
  assign outPc    = pcQ;
  assign outInstr = instrQ;

endmodule

// File: rtl/if_stage.sv
// LEGv8 instruction-fetch stage with IF/ID register, stall skid and redirect handling.
// Optional performance counters are enabled by defining IF_STAGE_PERF_EN.
module if_stage
  import legv8_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               id_stall,
  output logic               ifid_valid,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [10:0]        ifid_opcode
`ifdef IF_STAGE_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall_cyc,
  output logic [31:0]        perf_flush
`endif
);

  fetch_state_t       stateQ, stateD;
  logic [ADDR_W-1:0]  pcQ, pcD;
  logic [ADDR_W-1:0]  inflightPcQ, inflightPcD;
  logic               ifidValidQ, ifidValidD;
  logic [ADDR_W-1:0]  ifidPcQ, ifidPcD;
  logic [INSTR_W-1:0] ifidInstrQ, ifidInstrD;

  logic               canAccept;
  logic               ifidLoad;
  logic [ADDR_W-1:0]  pcInc;
  logic               skidLoad, skidUnload, skidClear, skidFull;
  logic [ADDR_W-1:0]  skidPc;
  logic [INSTR_W-1:0] skidInstr;

  assign canAccept = !id_stall || !ifidValidQ;
  assign pcInc     = inflightPcQ + ADDR_W'(PC_STEP);

  fetch_skid_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) uSkid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (skidLoad),
    .unload   (skidUnload),
    .clear    (skidClear),
    .inPc     (inflightPcQ),
    .inInstr  (imem_rdata),
    .full     (skidFull),
    .outPc    (skidPc),
    .outInstr (skidInstr)
  );

  always_comb begin
    stateD      = stateQ;
    pcD         = pcQ;
    inflightPcD = inflightPcQ;
    ifidValidD  = ifidValidQ;
    ifidPcD     = ifidPcQ;
    ifidInstrD  = ifidInstrQ;
    skidLoad    = 1'b0;
    skidUnload  = 1'b0;
    skidClear   = 1'b0;
    ifidLoad    = 1'b0;

    // Decode drains the current entry whenever it is able to accept.
    if (canAccept) begin
      ifidValidD = 1'b0;
    end

    if (redirect_valid) begin
      pcD        = redirect_pc & ~ADDR_W'(3);
      ifidValidD = 1'b0;
      skidClear  = 1'b1;
      unique case (stateQ)
        REQ:     stateD = imem_gnt ? DRAIN : REQ;
        WAIT:    stateD = imem_rvalid ? REQ : DRAIN;
        DRAIN:   stateD = imem_rvalid ? REQ : DRAIN;
        default: stateD = REQ;
      endcase
    end else begin
      unique case (stateQ)
        IDLE: stateD = REQ;
        REQ: begin
          if (imem_gnt) begin
            inflightPcD = pcQ;
            stateD      = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            pcD = pcInc;
            if (canAccept) begin
              ifidValidD = 1'b1;
              ifidPcD    = inflightPcQ;
              ifidInstrD = imem_rdata;
              ifidLoad   = 1'b1;
              stateD     = REQ;
            end else begin
              skidLoad = 1'b1;
              stateD   = HOLD;
            end
          end
        end
        HOLD: begin
          if (canAccept) begin
            if (skidFull) begin
              ifidValidD = 1'b1;
              ifidPcD    = skidPc;
              ifidInstrD = skidInstr;
              ifidLoad   = 1'b1;
            end
            skidUnload = 1'b1;
            stateD     = REQ;
          end
        end
        DRAIN: begin
          if (imem_rvalid) begin
            stateD = REQ;
          end
        end
        default: stateD = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ      <= IDLE;
      pcQ         <= RESET_PC;
      inflightPcQ <= '0;
      ifidValidQ  <= 1'b0;
      ifidPcQ     <= '0;
      ifidInstrQ  <= '0;
    end else begin
      stateQ      <= stateD;
      pcQ         <= pcD;
      inflightPcQ <= inflightPcD;
      ifidValidQ  <= ifidValidD;
      ifidPcQ     <= ifidPcD;
      ifidInstrQ  <= ifidInstrD;
    end
  end

  assign imem_req    = (stateQ == REQ);
  assign imem_addr   = pcQ;
  assign ifid_valid  = ifidValidQ;
  assign ifid_pc     = ifidPcQ;
  assign ifid_instr  = ifidInstrQ;
  assign ifid_opcode = ifidInstrQ[OPCODE_MSB:OPCODE_LSB];

`ifdef IF_STAGE_PERF_EN
  logic [31:0] perfFetchedQ, perfStallQ, perfFlushQ;

  // Counters saturate rather than wrap so long runs never read back as small values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perfFetchedQ <= '0;
      perfStallQ   <= '0;
      perfFlushQ   <= '0;
    end else begin
      if (ifidLoad && (perfFetchedQ != 32'hFFFF_FFFF)) begin
        perfFetchedQ <= perfFetchedQ + 32'd1;
      end
      if (id_stall && ifidValidQ && (perfStallQ != 32'hFFFF_FFFF)) begin
        perfStallQ <= perfStallQ + 32'd1;
      end
      if (redirect_valid && (perfFlushQ != 32'hFFFF_FFFF)) begin
        perfFlushQ <= perfFlushQ + 32'd1;
      end
    end
  end

  assign perf_fetched   = perfFetchedQ;
  assign perf_stall_cyc = perfStallQ;
  assign perf_flush     = perfFlushQ;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed cycle table, reset sequence, random stream check.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_stall;
  logic        ifid_valid;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic [10:0] ifid_opcode;
`ifdef IF_STAGE_PERF_EN
  logic [31:0] perf_fetched, perf_stall_cyc, perf_flush;
`endif

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr),
    .ifid_opcode    (ifid_opcode)
`ifdef IF_STAGE_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush     (perf_flush)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        stall;
    logic        redir;
    logic [63:0] redirPc;
    logic        expReq;
    logic [63:0] expAddr;
    logic        expValid;
    logic [63:0] expPc;
    logic [31:0] expInstr;
  } vec_t;

  vec_t vecs[$];
  int   nCmp = 0;
  int   nBad = 0;

  localparam logic [31:0] WA = 32'hF8400000;  // LDUR, opcode 7C2
  localparam logic [31:0] WB = 32'h8B020020;  // ADD, opcode 458
  localparam logic [31:0] WD = 32'hDEADBEEF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic g, input logic rv, input logic [31:0] rd, input logic st,
                        input logic rdir, input logic [63:0] rpc, input logic er,
                        input logic [63:0] ea, input logic ev, input logic [63:0] ep,
                        input logic [31:0] ei);
    vec_t v;
    v = '{g, rv, rd, st, rdir, rpc, er, ea, ev, ep, ei};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd, input logic st,
                       input logic rdir, input logic [63:0] rpc);
    imem_gnt       = g;
    imem_rvalid    = rv;
    imem_rdata     = rd;
    id_stall       = st;
    redirect_valid = rdir;
    redirect_pc    = rpc;
  endtask

  function automatic logic [31:0] memWord(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A1234;
  endfunction

  function automatic logic [10:0] opOf(input logic [31:0] w);
    return w[31:21];
  endfunction

  // Random-phase state
  logic [63:0] expPc, owedAddr, tgt;
  logic [63:0] prevAddr, prevPc;
  logic [31:0] prevInstr, rd;
  logic        owed, prevReq, prevGnt, prevRedir, prevV, prevStall;
  logic        g, rv, st, rdir;
  int          cnt, delivered;

  initial begin
    rst_n = 1'b0;
    drive(0, 0, '0, 0, 0, '0);

    //     gnt rv rdata st rd rpc                     req addr                   v  pc                       instr
    addVec(0, 0, '0, 0, 0, '0,                        1, 64'h0,                  0, '0,                      '0); // 0
    addVec(1, 0, '0, 0, 0, '0,                        0, '0,                     0, '0,                      '0);
    addVec(0, 1, WA, 0, 0, '0,                        1, 64'h4,                  1, 64'h0,                   WA);
    addVec(1, 0, '0, 0, 0, '0,                        0, '0,                     0, '0,                      '0);
    addVec(0, 1, WA, 0, 0, '0,                        1, 64'h8,                  1, 64'h4,                   WA);
    addVec(1, 0, '0, 0, 0, '0,                        0, '0,                     0, '0,                      '0); // 5
    addVec(0, 1, WA, 0, 0, '0,                        1, 64'hC,                  1, 64'h8,                   WA);
    addVec(1, 0, '0, 1, 0, '0,                        0, '0,                     1, 64'h8,                   WA);
    addVec(0, 1, WB, 1, 0, '0,                        0, '0,                     1, 64'h8,                   WA);
    addVec(0, 0, '0, 1, 0, '0,                        0, '0,                     1, 64'h8,                   WA);
    addVec(0, 0, '0, 1, 0, '0,                        0, '0,                     1, 64'h8,                   WA); // 10
    addVec(0, 0, '0, 1, 0, '0,                        0, '0,                     1, 64'h8,                   WA);
    addVec(0, 0, '0, 0, 0, '0,                        1, 64'h10,                 1, 64'hC,                   WB);
    addVec(1, 0, '0, 0, 0, '0,                        0, '0,                     0, '0,                      '0);
    addVec(0, 1, WA, 0, 0, '0,                        1, 64'h14,                 1, 64'h10,                  WA);
    addVec(1, 0, '0, 0, 0, '0,                        0, '0,                     0, '0,                      '0); // 15
    addVec(0, 0, '0, 0, 1, 64'h103,                   0, '0,                     0, '0,                      '0);
    addVec(0, 0, '0, 0, 0, '0,                        0, '0,                     0, '0,                      '0);
    addVec(0, 0, '0, 0, 0, '0,                        0, '0,                     0, '0,                      '0);
    addVec(0, 1, WD, 0, 0, '0,                        1, 64'h100,                0, '0,                      '0);
    addVec(1, 0, '0, 0, 0, '0,                        0, '0,                     0, '0,                      '0); // 20
    addVec(0, 1, WA, 0, 1, 64'h200,                   1, 64'h200,                0, '0,                      '0);
    addVec(0, 0, '0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE,   1, 64'hFFFF_FFFF_FFFF_FFFC, 0, '0,                     '0);
    addVec(1, 0, '0, 0, 0, '0,                        0, '0,                     0, '0,                      '0);
    addVec(0, 1, WB, 0, 0, '0,                        1, 64'h0,                  1, 64'hFFFF_FFFF_FFFF_FFFC, WB);
    addVec(1, 0, '0, 0, 1, 64'h40,                    0, '0,                     0, '0,                      '0); // 25
    addVec(0, 1, WA, 0, 0, '0,                        1, 64'h40,                 0, '0,                      '0);
    addVec(1, 0, '0, 0, 0, '0,                        0, '0,                     0, '0,                      '0);
    addVec(0, 1, WA, 0, 0, '0,                        1, 64'h44,                 1, 64'h40,                  WA);
    addVec(1, 0, '0, 1, 0, '0,                        0, '0,                     1, 64'h40,                  WA);
    addVec(0, 0, '0, 1, 1, 64'h80,                    0, '0,                     0, '0,                      '0); // 30
    addVec(0, 1, WA, 0, 0, '0,                        1, 64'h80,                 0, '0,                      '0);
    addVec(1, 0, '0, 0, 0, '0,                        0, '0,                     0, '0,                      '0);
    addVec(0, 1, WA, 0, 0, '0,                        1, 64'h84,                 1, 64'h80,                  WA);
    addVec(1, 0, '0, 1, 0, '0,                        0, '0,                     1, 64'h80,                  WA);

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst.req", imem_req, 0);
    chk("rst.valid", ifid_valid, 0);
    chk("rst.pc", ifid_pc, 0);
    chk("rst.instr", ifid_instr, 0);
    chk("rst.addr", imem_addr, 0);
`ifdef IF_STAGE_PERF_EN
    chk("rst.perf", {perf_fetched, perf_stall_cyc} | 64'(perf_flush), 0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      logic [31:0] ei;
      v = vecs[i];
      drive(v.gnt, v.rvalid, v.rdata, v.stall, v.redir, v.redirPc);
      @(negedge clk);
      chk($sformatf("row%0d.req", i), imem_req, v.expReq);
      if (v.expReq) chk($sformatf("row%0d.addr", i), imem_addr, v.expAddr);
      chk($sformatf("row%0d.valid", i), ifid_valid, v.expValid);
      if (v.expValid) begin
        ei = v.expInstr;
        chk($sformatf("row%0d.pc", i), ifid_pc, v.expPc);
        chk($sformatf("row%0d.instr", i), ifid_instr, v.expInstr);
        chk($sformatf("row%0d.opcode", i), ifid_opcode, opOf(ei));
      end
    end

    // Reset asserted mid-WAIT with a valid IF/ID entry
    rst_n = 1'b0;
    drive(0, 0, '0, 0, 0, '0);
    #1;
    chk("midrst.valid", ifid_valid, 0);
    chk("midrst.req", imem_req, 0);
    chk("midrst.pc", ifid_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, WD, 0, 0, '0);  // stray response while IDLE
    #1;
    chk("rel.req0", imem_req, 0);
    @(negedge clk);
    chk("rel.req1", imem_req, 1);
    chk("rel.addr", imem_addr, 0);
    chk("rel.valid", ifid_valid, 0);
    @(negedge clk);  // stray rvalid still high while in REQ
    chk("stray.req", imem_req, 1);
    chk("stray.valid", ifid_valid, 0);
    drive(1, 0, '0, 0, 0, '0);
    @(negedge clk);
    drive(0, 1, WB, 0, 0, '0);
    @(negedge clk);
    chk("post.valid", ifid_valid, 1);
    chk("post.pc", ifid_pc, 0);
    chk("post.instr", ifid_instr, WB);
    chk("post.addr", imem_addr, 64'h4);

    // Randomized phase against a program-order stream model
    rst_n = 1'b0;
    drive(0, 0, '0, 0, 0, '0);
    @(negedge clk);
    rst_n     = 1'b1;
    expPc     = 64'h0;
    owed      = 1'b0;
    owedAddr  = '0;
    cnt       = 0;
    delivered = 0;
    prevReq   = 0; prevGnt = 0; prevRedir = 0; prevV = 0; prevStall = 0;
    prevAddr  = '0; prevPc = '0; prevInstr = '0;
    for (int c = 0; c < 4000; c++) begin
      if (ifid_valid) chk("rnd.opcode", ifid_opcode, opOf(ifid_instr));
      if (owed) chk("rnd.oneOutstanding", imem_req, 0);
      if (prevReq && !prevGnt && !prevRedir) begin
        chk("rnd.reqHeld", imem_req, 1);
        chk("rnd.addrStable", imem_addr, prevAddr);
      end
      if (prevV && prevStall && !prevRedir) begin
        chk("rnd.freezeV", ifid_valid, 1);
        chk("rnd.freezePc", ifid_pc, prevPc);
        chk("rnd.freezeInstr", ifid_instr, prevInstr);
      end

      rv = 0;
      rd = $urandom;
      if (owed) begin
        cnt--;
        if (cnt == 0) begin
          rv   = 1;
          rd   = memWord(owedAddr);
          owed = 0;
        end
      end
      g = 0;
      if (imem_req && !owed && !rv && ($urandom_range(0, 1) == 1)) begin
        g        = 1;
        owed     = 1;
        owedAddr = imem_addr;
        cnt      = $urandom_range(1, 3);
      end
      st   = ($urandom_range(0, 99) < 30);
      rdir = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      else tgt = {$urandom, $urandom};

      if (ifid_valid && !st && !rdir) begin
        chk("rnd.pcOrder", ifid_pc, expPc);
        chk("rnd.data", ifid_instr, memWord(ifid_pc));
        expPc = expPc + 64'd4;
        delivered++;
      end
      if (rdir) expPc = tgt & ~64'd3;

      prevReq   = imem_req;
      prevAddr  = imem_addr;
      prevV     = ifid_valid;
      prevPc    = ifid_pc;
      prevInstr = ifid_instr;
      prevGnt   = g;
      prevRedir = rdir;
      prevStall = st;
      drive(g, rv, rd, st, rdir, tgt);
      @(negedge clk);
    end
    chk("rnd.progress", (delivered >= 200), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage with IF/ID pipeline register for the LEGv8 datapath.
- Holds the PC and issues one instruction-memory request at a time.
- Captures the returned word and presents it to decode: ifid_opcode feeds the control unit, which decodes instr[31:21].
- Handles decode back-pressure (stall) and branch redirects (flush) from downstream.

Parameters:
- ADDR_W, 64, PC / instruction-address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  request valid; held until imem_gnt.
- imem_addr  out  ADDR_W  word-aligned fetch address; stable while imem_req=1.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; arrives at least 1 cycle after gnt.
- imem_rdata  in  INSTR_W  instruction word.
- redirect_valid  in  1  branch taken / flush request from EX.
- redirect_pc  in  ADDR_W  new PC; bits [1:0] are ignored and forced to 0.
- id_stall  in  1  decode cannot accept a new IF/ID entry this cycle.
- ifid_valid  out  1  IF/ID entry valid.
- ifid_pc  out  ADDR_W  PC of the IF/ID instruction.
- ifid_instr  out  INSTR_W  IF/ID instruction.
- ifid_opcode  out  11  equals ifid_instr[31:21].

Behaviour:
- Reset values (asynchronous on rst_n=0):
  - pc=RESET_PC, state=IDLE.
  - imem_req=0, ifid_valid=0, ifid_pc=0, ifid_instr=0, skid buffer empty.
- All outputs are registered or decoded from state only. No combinational path from inputs to imem_req or imem_addr.
- FSM states and transitions:
  - IDLE: imem_req=0. Always moves to REQ next cycle, so the first request appears 1 cycle after reset release.
  - REQ: imem_req=1, imem_addr=pc. On imem_gnt: latch inflight_pc=pc and go to WAIT.
  - WAIT: on imem_rvalid, if IF/ID can accept, load IF/ID with {1, inflight_pc, rdata}, set pc=inflight_pc+4, and go to REQ. Otherwise store the word in the skid buffer, set pc=inflight_pc+4, and go to HOLD.
  - HOLD: no request is issued. When IF/ID can accept, move the skid entry into IF/ID and go to REQ.
  - DRAIN: one response is owed and must be discarded. On imem_rvalid, drop the data and go to REQ.
- "IF/ID can accept" means id_stall=0 or ifid_valid=0.
- If id_stall=1 and ifid_valid=1, IF/ID holds all fields unchanged.
- If IF/ID empties into decode with no new data, ifid_valid is cleared to 0.
- Redirect has highest priority and is processed the same cycle, overriding id_stall:
  - pc=redirect_pc & ~3; ifid_valid=0; skid buffer cleared.
  - If the state is WAIT, or the state is REQ with imem_gnt=1 in the same cycle, go to DRAIN.
  - If the state is WAIT with imem_rvalid=1 in the same cycle, drop the data and go to REQ.
  - From IDLE, REQ (without gnt), or HOLD, go to REQ.
  - From DRAIN, stay in DRAIN unless imem_rvalid=1, in which case go to REQ.
- PC arithmetic: +4 modulo 2^ADDR_W; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- Throughput: at most one outstanding request. Best case is one instruction per 2 cycles (gnt in REQ, rvalid the following cycle).
- Reset asserted mid-transaction: all state is cleared immediately. A late imem_rvalid after reset release is ignored, because only WAIT and DRAIN sample it.

Optional Feature:
- Macro: IF_STAGE_PERF_EN.
- Defined: adds outputs perf_fetched (32b), perf_stall_cyc (32b), and perf_flush (32b), all reset to 0 and saturating at 32'hFFFF_FFFF.
  - perf_fetched increments per word loaded into IF/ID.
  - perf_stall_cyc increments per cycle with id_stall=1 and ifid_valid=1.
  - perf_flush increments per redirect_valid cycle.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package legv8_pkg holds:
  - fetch_state_t enum {IDLE, REQ, WAIT, HOLD, DRAIN}.
  - OPCODE_MSB=31, OPCODE_LSB=21.
  - PC_STEP=4.
  - INSTR_NOP=32'hD503201F.
- Sub-module fetch_skid_buf: a 1-entry {pc, instr} holding register with load, unload, and clear controls, instantiated once.

Test Plan:
- Reset release, RESET_PC=0, gnt/rvalid immediate, rdata=32'hF8400000 → ifid_pc sequence 0,4,8; ifid_opcode=11'h7C2; IF/ID updates every 2 cycles.
- id_stall=1 for 5 cycles while ifid_valid=1 → ifid_pc/ifid_instr frozen; next word parked in skid (HOLD); on release the words come out in order with no loss or duplication.
- Redirect to 64'h103 while in WAIT; old rvalid arrives 3 cycles later with 32'hDEADBEEF → data dropped, ifid_valid=0, next imem_addr=64'h100.
- Redirect in the same cycle as imem_rvalid in WAIT → data discarded, next cycle imem_req=1 with the redirect address, no DRAIN.
- pc=64'hFFFF_FFFF_FFFF_FFFC fetch → next imem_addr=0.
- rst_n pulsed low mid-WAIT → ifid_valid=0 immediately, imem_req=0 for 1 cycle after release, then imem_addr=RESET_PC; a stray rvalid during IDLE is ignored.
